// File: rtl/input_port_if.sv
// Link-side bundle for input_port: incoming flit, ready, per-lane back-pressure and lane data.
// dropCount is present only when INPUT_PORT_DROP_CNT_EN is defined.
interface input_port_if #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         inData;
    logic                          inReady;
    logic [3:0]                    portBlock;
    logic [DATA_WIDTH-1:0]         outData0;
    logic [DATA_WIDTH-1:0]         outData1;
    logic [DATA_WIDTH-1:0]         outData2;
    logic [DATA_WIDTH-1:0]         outData3;
    logic [$clog2(FIFO_DEPTH):0]   fifoCount;
`ifdef INPUT_PORT_DROP_CNT_EN
    logic [7:0]                    dropCount;

    modport slave (
        input  inData, portBlock,
        output inReady, outData0, outData1, outData2, outData3, fifoCount, dropCount
    );
    modport master (
        output inData, portBlock,
        input  inReady, outData0, outData1, outData2, outData3, fifoCount, dropCount
    );
`else
    modport slave (
        input  inData, portBlock,
        output inReady, outData0, outData1, outData2, outData3, fifoCount
    );
    modport master (
        output inData, portBlock,
        input  inReady, outData0, outData1, outData2, outData3, fifoCount
    );
`endif
endinterface

// File: rtl/input_port.sv
// Router ingress: buffers valid flits in a small FIFO and forwards them in order to one of four lanes.
// Optional saturating drop counter enabled by defining INPUT_PORT_DROP_CNT_EN.
module input_port #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input_port_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wrPtr_q;
    logic [PW-1:0]          rdPtr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [DATA_WIDTH-1:0]  outData_q [4];
    logic [DATA_WIDTH-1:0]  head;
    logic [1:0]             headDest;
    logic                   ready;
    logic                   push;
    logic                   pop;

    // Readiness looks only at the registered count, so a same-edge pop never frees a slot.
    assign ready    = (count_q != CW'(FIFO_DEPTH));
    assign push     = bus.inData[DATA_WIDTH-1] && ready;
    assign head     = mem_q[rdPtr_q];
    assign headDest = head[DATA_WIDTH-2 -: 2];
    assign pop      = (state_q == WAIT) && !bus.portBlock[headDest];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= bus.inData;
        end
    end

    // WAIT holds the head until its lane is free; SEND presents it for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                outData_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (pop) begin
                        outData_q[headDest] <= head;
                        state_q             <= SEND;
                    end
                end
                SEND: begin
                    for (int i = 0; i < 4; i++) begin
                        outData_q[i] <= '0;
                    end
                    state_q <= (count_q != '0) ? WAIT : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.inReady   = ready;
    assign bus.fifoCount = count_q;
    assign bus.outData0  = outData_q[0];
    assign bus.outData1  = outData_q[1];
    assign bus.outData2  = outData_q[2];
    assign bus.outData3  = outData_q[3];

`ifdef INPUT_PORT_DROP_CNT_EN
    logic [7:0] dropCount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropCount_q <= '0;
        end else if (bus.inData[DATA_WIDTH-1] && !ready && (dropCount_q != 8'hFF)) begin
            dropCount_q <= dropCount_q + 1'b1;
        end
    end

    assign bus.dropCount = dropCount_q;
`endif
endmodule

// File: tb/tb_input_port.sv
// Self-checking bench for input_port: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_input_port;
    localparam int DW    = 14;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    input_port_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    input_port #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    logic [DW-1:0] mq [$];
    logic [DW-1:0] mOut [4];
    bit            mArmed;
    bit            mJustSent;
    int            mDrops;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] flit(input logic [1:0] dest, input logic [10:0] payload);
        return {1'b1, dest, payload};
    endfunction

    // Reference: a queue of flits; a newly non-empty queue costs one notice cycle, each
    // dispatch shows on its lane for one cycle and is followed by one idle cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mOut[i] = '0;
            mArmed    = 1'b0;
            mJustSent = 1'b0;
            mDrops    = 0;
        end else begin : modelStep
            bit            full;
            logic [DW-1:0] h;
            int            d;
            full = (mq.size() >= DEPTH);
            if (mJustSent) begin
                for (int i = 0; i < 4; i++) mOut[i] = '0;
                mJustSent = 1'b0;
                mArmed    = (mq.size() != 0);
            end else if (mArmed) begin
                h = mq[0];
                d = int'(h[12:11]);
                if (!bus.portBlock[d]) begin
                    mOut[d] = h;
                    void'(mq.pop_front());
                    mJustSent = 1'b1;
                end
            end else begin
                mArmed = (mq.size() != 0);
            end
            if (bus.inData[13]) begin
                if (!full) mq.push_back(bus.inData);
                else if (mDrops < 255) mDrops++;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin : cmp
            int lanes;
            checkOutput("outData0", 32'(bus.outData0), 32'(mOut[0]));
            checkOutput("outData1", 32'(bus.outData1), 32'(mOut[1]));
            checkOutput("outData2", 32'(bus.outData2), 32'(mOut[2]));
            checkOutput("outData3", 32'(bus.outData3), 32'(mOut[3]));
            checkOutput("fifoCount", 32'(bus.fifoCount), 32'(mq.size()));
            checkOutput("inReady", 32'(bus.inReady), 32'(mq.size() < DEPTH));
`ifdef INPUT_PORT_DROP_CNT_EN
            checkOutput("dropCount", 32'(bus.dropCount), 32'(mDrops));
`endif
            lanes = 32'(bus.outData0 != '0) + 32'(bus.outData1 != '0)
                  + 32'(bus.outData2 != '0) + 32'(bus.outData3 != '0);
            checkOutput("oneLaneAtMost", 32'(lanes > 1), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [3:0] pb, input int n);
        bus.inData    = d;
        bus.portBlock = pb;
        repeat (n) tick();
    endtask

    function automatic bit anyOut();
        return (bus.outData0 | bus.outData1 | bus.outData2 | bus.outData3) != '0;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [1:0] dests [4];
        int         lane [$];
        int         cyc [$];
        logic [DW-1:0] seen [$];
        int         emits;

        dests = '{2'd3, 2'd0, 2'd2, 2'd1};
        bus.inData    = '0;
        bus.portBlock = '0;
        reset         = 1'b1;
        repeat (2) tick();
        checkOutput("rst fifoCount", 32'(bus.fifoCount), 32'd0);
        checkOutput("rst inReady", 32'(bus.inReady), 32'd1);
        checkOutput("rst anyOut", 32'(anyOut()), 32'd0);
        reset   = 1'b0;
        checkEn = 1'b1;

        // Single flit to lane 1, unblocked.
        applyStimulus(14'b1_01_00000000101, 4'h0, 1);
        checkOutput("t1 count after push", 32'(bus.fifoCount), 32'd1);
        applyStimulus('0, 4'h0, 1);
        checkOutput("t1 out1 at E1", 32'(bus.outData1), 32'd0);
        tick();
        checkOutput("t1 out1 at E2", 32'(bus.outData1), 32'(14'b10100000000101));
        checkOutput("t1 out0 at E2", 32'(bus.outData0), 32'd0);
        checkOutput("t1 out2 at E2", 32'(bus.outData2), 32'd0);
        checkOutput("t1 out3 at E2", 32'(bus.outData3), 32'd0);
        checkOutput("t1 count at E2", 32'(bus.fifoCount), 32'd0);
        tick();
        checkOutput("t1 out1 at E3", 32'(bus.outData1), 32'd0);

        // Head blocked on lane 2, then released.
        applyStimulus(14'b1_10_00000000011, 4'b0100, 1);
        bus.inData = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t2 held anyOut", 32'(anyOut()), 32'd0);
            checkOutput("t2 held count", 32'(bus.fifoCount), 32'd1);
        end
        bus.portBlock = 4'h0;
        tick();
        checkOutput("t2 out2 released", 32'(bus.outData2), 32'(14'b11000000000011));
        tick();
        checkOutput("t2 out2 cleared", 32'(bus.outData2), 32'd0);

        // Fill while blocked, overflow, then pop-while-full with a blocked write.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(flit(2'(i % 4), 11'(i + 16)), 4'hF, 1);
            if (i == 3) begin
                checkOutput("t3 full count", 32'(bus.fifoCount), 32'd4);
                checkOutput("t3 full inReady", 32'(bus.inReady), 32'd0);
            end
        end
        checkOutput("t3 count after drop", 32'(bus.fifoCount), 32'd4);
`ifdef INPUT_PORT_DROP_CNT_EN
        checkOutput("t3 dropCount", 32'(bus.dropCount), 32'd1);
`endif
        applyStimulus(flit(2'd1, 11'h7FF), 4'h0, 1);
        bus.inData = '0;
        checkOutput("t3 count pop while full", 32'(bus.fifoCount), 32'd3);
`ifdef INPUT_PORT_DROP_CNT_EN
        checkOutput("t3 dropCount second", 32'(bus.dropCount), 32'd2);
`endif
        emits = int'(anyOut());
        for (int i = 0; i < 10; i++) begin
            tick();
            if (anyOut()) emits++;
        end
        checkOutput("t3 emitted flits", 32'(emits), 32'd4);
        checkOutput("t3 drained", 32'(bus.fifoCount), 32'd0);

        // Four flits to lanes 3,0,2,1 back to back.
        for (int c = 0; c < 14; c++) begin
            bus.inData    = (c < 4) ? flit(dests[c], 11'(c + 1)) : '0;
            bus.portBlock = 4'h0;
            tick();
            if (bus.outData0 != '0) begin lane.push_back(0); cyc.push_back(c); seen.push_back(bus.outData0); end
            if (bus.outData1 != '0) begin lane.push_back(1); cyc.push_back(c); seen.push_back(bus.outData1); end
            if (bus.outData2 != '0) begin lane.push_back(2); cyc.push_back(c); seen.push_back(bus.outData2); end
            if (bus.outData3 != '0) begin lane.push_back(3); cyc.push_back(c); seen.push_back(bus.outData3); end
        end
        checkOutput("t4 emit count", 32'(lane.size()), 32'd4);
        if (lane.size() == 4) begin
            checkOutput("t4 first cycle", 32'(cyc[0]), 32'd2);
            for (int k = 0; k < 4; k++) begin
                checkOutput("t4 lane order", 32'(lane[k]), 32'(dests[k]));
                checkOutput("t4 flit data", 32'(seen[k]), 32'(flit(dests[k], 11'(k + 1))));
                if (k > 0) checkOutput("t4 spacing", 32'(cyc[k] - cyc[k-1]), 32'd2);
            end
        end

        // Queue behind a fully blocked output, then reset mid-operation.
        for (int i = 0; i < 3; i++) applyStimulus(flit(2'(i), 11'(i + 40)), 4'hF, 1);
        applyStimulus('0, 4'hF, 2);
        checkOutput("t5 queued", 32'(bus.fifoCount), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("t5 reset count", 32'(bus.fifoCount), 32'd0);
        checkOutput("t5 reset anyOut", 32'(anyOut()), 32'd0);
        checkOutput("t5 reset inReady", 32'(bus.inReady), 32'd1);
        tick();
        reset         = 1'b0;
        bus.portBlock = 4'h0;
        emits = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (anyOut()) emits++;
        end
        checkOutput("t5 nothing after reset", 32'(emits), 32'd0);

        // Flit without the valid bit is ignored.
        applyStimulus(14'b0_01_11111111111, 4'h0, 1);
        bus.inData = '0;
        emits = 0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6 count stays 0", 32'(bus.fifoCount), 32'd0);
            if (anyOut()) emits++;
            tick();
        end
        checkOutput("t6 no activity", 32'(emits), 32'd0);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
